mmio_timer: RTL and testbench

MMIO_TIMER -- requirements
Module: mmio_timer

---
 rtl/mmio_timer.sv | 173 +++++++++++++++++
 tb/tb_mmio_timer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mmio_timer.sv
// ---------------------------------------------------------------------------
// mmio_timer -- memory-mapped 64-bit machine timer with compare interrupt.
//
// A prescaler divides clk by DIV = ClockFreqHz/TickHz. Each prescaler tick
// advances the 64-bit mtime counter. PEND is set whenever mtime >= CMP, and
// irq_o is the registered PEND & IE.
//
// Register map (word offsets):
//   0 MTIME_LO   1 MTIME_HI (snapshot taken on the MTIME_LO read)
//   2 CMP_LO     3 CMP_HI
//   4 CTRL       bit0 EN, bit1 IE
//   5 STATUS     bit0 PEND (write 1 to clear)
//   6-15         read 0, writes ignored
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   addr         register word offset
//   wdata        write data
//   byte_en      write byte-lane enables
//   wr           1 = write, 0 = read
//   addr_strobe  one-cycle access qualifier
//   data         registered read data (latency 1, holds between reads)
//   irq_o        registered interrupt request
// ---------------------------------------------------------------------------
module mmio_timer #(
    parameter int ClockFreqHz = 50000000,
    parameter int TickHz      = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byte_en,
    input  logic        wr,
    input  logic        addr_strobe,
    output logic [31:0] data,
    output logic        irq_o
);

    localparam int DIV_RAW = ClockFreqHz / TickHz;
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    localparam logic [3:0] ADDR_MTIME_LO = 4'd0;
    localparam logic [3:0] ADDR_MTIME_HI = 4'd1;
    localparam logic [3:0] ADDR_CMP_LO   = 4'd2;
    localparam logic [3:0] ADDR_CMP_HI   = 4'd3;
    localparam logic [3:0] ADDR_CTRL     = 4'd4;
    localparam logic [3:0] ADDR_STATUS   = 4'd5;

    logic [63:0]   mtime_reg, mtime_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic [31:0]   snap_reg, snap_next;
    logic [63:0]   cmp_reg, cmp_next;
    logic [1:0]    ctrl_reg, ctrl_next;
    logic          pend_reg, pend_next;
    logic [31:0]   data_reg, data_next;
    logic          irq_reg, irq_next;

    logic [31:0] lane_mask;
    logic [31:0] rdata;
    logic [31:0] ctrl_merged;
    logic        wr_en, rd_en;
    logic        tick;
    logic        cmp_hit;
    logic        pend_clear;

    // Expand byte_en into a 32-bit write mask, one byte lane per enable bit.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_mask[8*gi +: 8] = {8{byte_en[gi]}};
        end
    endgenerate

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    assign wr_en = addr_strobe & wr;
    assign rd_en = addr_strobe & ~wr;

    assign tick    = ctrl_reg[0] && (presc_reg == PRESC_LAST);
    // Compare uses the registered values from the start of the cycle.
    assign cmp_hit = (mtime_reg >= cmp_reg);
    assign pend_clear = wr_en && (addr == ADDR_STATUS) && byte_en[0] && wdata[0];
    assign ctrl_merged = merge_lanes({30'd0, ctrl_reg}, wdata, lane_mask);

    always_comb begin
        // Prescaler: held at 0 while disabled, wraps to 0 after DIV-1.
        presc_next = '0;
        if (ctrl_reg[0] && !tick) begin
            presc_next = presc_reg + PW'(1);
        end

        // Bus writes to mtime take priority; a coincident tick is dropped.
        mtime_next = mtime_reg;
        if (wr_en && addr == ADDR_MTIME_LO) begin
            mtime_next[31:0] = merge_lanes(mtime_reg[31:0], wdata, lane_mask);
        end else if (wr_en && addr == ADDR_MTIME_HI) begin
            mtime_next[63:32] = merge_lanes(mtime_reg[63:32], wdata, lane_mask);
        end else if (tick) begin
            mtime_next = mtime_reg + 64'd1;
        end

        cmp_next = cmp_reg;
        if (wr_en && addr == ADDR_CMP_LO) begin
            cmp_next[31:0] = merge_lanes(cmp_reg[31:0], wdata, lane_mask);
        end
        if (wr_en && addr == ADDR_CMP_HI) begin
            cmp_next[63:32] = merge_lanes(cmp_reg[63:32], wdata, lane_mask);
        end

        ctrl_next = ctrl_reg;
        if (wr_en && addr == ADDR_CTRL) begin
            ctrl_next = ctrl_merged[1:0];
        end

        // Set has priority over the W1C clear.
        pend_next = cmp_hit | (pend_reg & ~pend_clear);

        // The high word is captured together with the low-word read so a
        // LO-then-HI read pair can never return a torn 64-bit value.
        snap_next = snap_reg;
        if (rd_en && addr == ADDR_MTIME_LO) begin
            snap_next = mtime_reg[63:32];
        end

        rdata = 32'd0;
        case (addr)
            ADDR_MTIME_LO: rdata = mtime_reg[31:0];
            ADDR_MTIME_HI: rdata = snap_reg;
            ADDR_CMP_LO:   rdata = cmp_reg[31:0];
            ADDR_CMP_HI:   rdata = cmp_reg[63:32];
            ADDR_CTRL:     rdata = {30'd0, ctrl_reg};
            ADDR_STATUS:   rdata = {31'd0, pend_reg};
            default:       rdata = 32'd0;
        endcase

        data_next = rd_en ? rdata : data_reg;
        irq_next  = pend_reg & ctrl_reg[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_reg <= '0;
            presc_reg <= '0;
            snap_reg  <= '0;
            cmp_reg   <= {64{1'b1}};
            ctrl_reg  <= '0;
            pend_reg  <= 1'b0;
            data_reg  <= '0;
            irq_reg   <= 1'b0;
        end else begin
            mtime_reg <= mtime_next;
            presc_reg <= presc_next;
            snap_reg  <= snap_next;
            cmp_reg   <= cmp_next;
            ctrl_reg  <= ctrl_next;
            pend_reg  <= pend_next;
            data_reg  <= data_next;
            irq_reg   <= irq_next;
        end
    end

    assign data  = data_reg;
    assign irq_o = irq_reg;

endmodule

// File: tb/tb_mmio_timer.sv
// ---------------------------------------------------------------------------
// tb_mmio_timer -- directed bench for mmio_timer.
// Two instances share the bus: u_div4 (DIV=4) and u_div1 (DIV=1). Every bus
// operation starts on a falling edge and ends on the next falling edge, so
// one operation occupies exactly one rising edge.
// ---------------------------------------------------------------------------
module tb_mmio_timer;

    logic        clk;
    logic        rst_n;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  byte_en;
    logic        wr;
    logic        addr_strobe;
    logic [31:0] data4, data1;
    logic        irq4, irq1;

    int checks;
    int errors;

    logic [31:0] r1, r4;

    mmio_timer #(.ClockFreqHz(4), .TickHz(1)) u_div4 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata),
        .byte_en(byte_en), .wr(wr), .addr_strobe(addr_strobe),
        .data(data4), .irq_o(irq4)
    );

    mmio_timer #(.ClockFreqHz(1), .TickHz(1)) u_div1 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata),
        .byte_en(byte_en), .wr(wr), .addr_strobe(addr_strobe),
        .data(data1), .irq_o(irq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-24s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        addr = a; wdata = d; byte_en = be; wr = 1'b1; addr_strobe = 1'b1;
        @(negedge clk);
        addr_strobe = 1'b0; wr = 1'b0;
        $display("write addr=%0d data=%h be=%b", a, d, be);
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d1, output logic [31:0] d4);
        addr = a; wdata = 32'd0; byte_en = 4'd0; wr = 1'b0; addr_strobe = 1'b1;
        @(negedge clk);
        addr_strobe = 1'b0;
        d1 = data1;
        d4 = data4;
        $display("read  addr=%0d div1=%h div4=%h", a, d1, d4);
    endtask

    // Asserts reset away from any clock edge and releases it on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; addr = 4'd0; wdata = 32'd0; byte_en = 4'd0;
        wr = 1'b0; addr_strobe = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check("reset_data1", data1, 32'd0);
        check("reset_irq1", {31'd0, irq1}, 32'd0);
        bus_read(4'd2, r1, r4); check("reset_cmp_lo", r1, 32'hFFFF_FFFF);
        bus_read(4'd3, r1, r4); check("reset_cmp_hi", r1, 32'hFFFF_FFFF);
        bus_read(4'd4, r1, r4); check("reset_ctrl", r1, 32'd0);
        bus_read(4'd5, r1, r4); check("reset_status", r1, 32'd0);
        bus_read(4'd0, r1, r4); check("reset_mtime_lo", r1, 32'd0);
        bus_write(4'd7, 32'h1234_5678, 4'hF);
        bus_read(4'd7, r1, r4); check("unmapped_read", r1, 32'd0);

        // Prescale: CTRL.EN=1, 40 cycles later DIV=4 -> 10, DIV=1 -> 40
        do_reset();
        bus_write(4'd4, 32'd1, 4'hF);
        repeat (40) @(negedge clk);
        bus_read(4'd0, r1, r4);
        check("presc_div4_lo", r4, 32'd10);
        check("presc_div1_lo", r1, 32'd40);
        bus_read(4'd1, r1, r4);
        check("presc_div4_hi", r4, 32'd0);

        // Interrupt: mtime reaches 20 after edge 22 -> PEND at 23, irq at 24
        do_reset();
        bus_write(4'd3, 32'd0, 4'hF);
        bus_write(4'd2, 32'd20, 4'hF);
        bus_write(4'd4, 32'd3, 4'hF);
        repeat (20) @(negedge clk);
        check("irq_before_match", {31'd0, irq1}, 32'd0);
        bus_read(4'd5, r1, r4);
        check("pend_before_match", r1, 32'd0);
        check("irq_same_as_pend", {31'd0, irq1}, 32'd0);
        bus_read(4'd5, r1, r4);
        check("pend_after_match", r1, 32'd1);
        check("irq_one_after_pend", {31'd0, irq1}, 32'd1);

        // Clear: set wins while compare still true; clears once CMP raised
        bus_write(4'd5, 32'd1, 4'hF);
        bus_read(4'd5, r1, r4);
        check("pend_set_wins", r1, 32'd1);
        bus_write(4'd2, 32'hFFFF_FFFF, 4'hF);
        bus_write(4'd5, 32'd1, 4'hF);
        check("irq_still_high", {31'd0, irq1}, 32'd1);
        bus_read(4'd5, r1, r4);
        check("pend_cleared", r1, 32'd0);
        check("irq_cleared", {31'd0, irq1}, 32'd0);

        // Snapshot across the 32-bit carry
        do_reset();
        bus_write(4'd0, 32'hFFFF_FFFE, 4'hF);
        bus_write(4'd1, 32'd0, 4'hF);
        bus_write(4'd4, 32'd1, 4'hF);
        bus_read(4'd0, r1, r4);
        check("snap_lo_pre_carry", r1, 32'hFFFF_FFFE);
        repeat (2) @(negedge clk);
        bus_read(4'd1, r1, r4);
        check("snap_hi_not_live", r1, 32'd0);
        bus_read(4'd0, r1, r4);
        check("snap_lo_post_carry", r1, 32'd2);
        bus_read(4'd1, r1, r4);
        check("snap_hi_post_carry", r1, 32'd1);

        // Byte lanes, CTRL masking, and write-over-tick priority
        do_reset();
        bus_write(4'd2, 32'hAABB_CCDD, 4'b0101);
        bus_read(4'd2, r1, r4);
        check("byte_lane_cmp_lo", r1, 32'hFFBB_FFDD);
        bus_write(4'd4, 32'hFFFF_FFFC, 4'hF);
        bus_read(4'd4, r1, r4);
        check("ctrl_reserved_bits", r1, 32'd0);
        bus_write(4'd4, 32'd1, 4'hF);
        bus_write(4'd0, 32'd5, 4'hF);
        bus_read(4'd0, r1, r4);
        check("write_beats_tick_div1", r1, 32'd5);
        check("write_mtime_div4", r4, 32'd5);

        // Asynchronous reset mid-count
        do_reset();
        bus_write(4'd3, 32'd0, 4'hF);
        bus_write(4'd2, 32'd0, 4'hF);
        bus_write(4'd4, 32'd3, 4'hF);
        repeat (5) @(negedge clk);
        bus_read(4'd0, r1, r4);
        check("pre_reset_mtime", r1, 32'd5);
        check("pre_reset_irq", {31'd0, irq1}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_data1", data1, 32'd0);
        check("async_rst_irq1", {31'd0, irq1}, 32'd0);
        check("async_rst_irq4", {31'd0, irq4}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(4'd2, r1, r4); check("post_rst_cmp_lo", r1, 32'hFFFF_FFFF);
        bus_read(4'd3, r1, r4); check("post_rst_cmp_hi", r4, 32'hFFFF_FFFF);
        repeat (3) @(negedge clk);
        bus_read(4'd0, r1, r4); check("post_rst_mtime_held", r1, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
